uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_engine.sv | 151 +++++++++++++++
 tb/tb_uart_tx_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: serialises one byte per frame (start, 8 data LSB first, optional parity, 1 or 2 stop bits).
// Latency: start bit is on txd the cycle after acceptance; a frame lasts rate*(10+parity+two_stop) cycles.
// Backpressure: tx_ready only in IDLE with an enabled, legal config; rate/mode/data are latched per frame.
module uart_tx_engine #(
   parameter int MIN_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_enable,
   input  logic [2:0]  uart_mode,
   input  logic [15:0] uart_rate,
   input  logic        tx_valid,
   input  logic [7:0]  tx_data,
   output logic        tx_ready,
   output logic        txd,
   output logic        uart_busy,
   output logic        uart_error,
   output logic        update_ok
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [15:0] rate_q;
   logic [7:0]  byte_q;
   logic [2:0]  mode_q;
   logic [2:0]  bit_idx;
   logic        stop_idx;

   logic        rate_ok;
   logic        bit_done;
   logic        parity_bit;
   logic [2:0]  next_idx;
   logic [15:0] reload;

   assign rate_ok    = (uart_rate >= 16'(MIN_DIV));
   assign bit_done   = (cnt == 16'd0);
   // Even parity is the XOR of the data bits; odd parity inverts it.
   assign parity_bit = (^byte_q) ^ mode_q[1];
   assign next_idx   = bit_idx + 3'd1;
   assign reload     = rate_q - 16'd1;

   // Accept only from IDLE with a usable divisor; never while reset is asserted.
   assign tx_ready = !rst && (state == IDLE) && uart_enable && rate_ok;

   // Frame sequencer: every bit is timed by cnt counting rate-1 down to 0 with the latched rate.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 16'd0;
         rate_q    <= 16'd0;
         byte_q    <= 8'd0;
         mode_q    <= 3'd0;
         bit_idx   <= 3'd0;
         stop_idx  <= 1'b0;
         txd       <= 1'b1;
         uart_busy <= 1'b0;
         update_ok <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               txd <= 1'b1;
               if (tx_valid && tx_ready) begin
                  byte_q    <= tx_data;
                  rate_q    <= uart_rate;
                  mode_q    <= uart_mode;
                  cnt       <= uart_rate - 16'd1;
                  state     <= START;
                  txd       <= 1'b0;
                  uart_busy <= 1'b1;
                  update_ok <= 1'b0;
               end
            end
            START: begin
               if (bit_done) begin
                  state   <= DATA;
                  cnt     <= reload;
                  bit_idx <= 3'd0;
                  txd     <= byte_q[0];
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  cnt <= reload;
                  if (bit_idx == 3'd7) begin
                     if (mode_q[0]) begin
                        state <= PARITY;
                        txd   <= parity_bit;
                     end else begin
                        state    <= STOP;
                        txd      <= 1'b1;
                        stop_idx <= 1'b0;
                     end
                  end else begin
                     bit_idx <= next_idx;
                     txd     <= byte_q[next_idx];
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            PARITY: begin
               if (bit_done) begin
                  state    <= STOP;
                  cnt      <= reload;
                  txd      <= 1'b1;
                  stop_idx <= 1'b0;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            STOP: begin
               if (bit_done) begin
                  if (mode_q[2] && !stop_idx) begin
                     // Second stop bit: another full bit period of mark.
                     stop_idx <= 1'b1;
                     cnt      <= reload;
                  end else begin
                     state     <= IDLE;
                     uart_busy <= 1'b0;
                     update_ok <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               state     <= IDLE;
               txd       <= 1'b1;
               uart_busy <= 1'b0;
               update_ok <= 1'b1;
            end
         endcase
      end
   end

   // Sticky flag for a byte offered with an illegal divisor; cleared by reset or disabling.
   always_ff @(posedge clk) begin
      if (rst) begin
         uart_error <= 1'b0;
      end else if (tx_valid && uart_enable && !rate_ok) begin
         uart_error <= 1'b1;
      end else if (!uart_enable) begin
         uart_error <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed frames checked every cycle against a bit-queue line model.
// Latency: model expects the start bit the cycle after an accepting edge.
// Backpressure: model derives readiness from its own queue occupancy.
module tb_uart_tx_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        uart_enable;
   logic [2:0]  uart_mode;
   logic [15:0] uart_rate;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        txd;
   logic        uart_busy;
   logic        uart_error;
   logic        update_ok;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   bit   mq[$];
   bit   m_err = 1'b0;
   logic cap [0:127];

   always #5 clk = ~clk;

   uart_tx_engine #(.MIN_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .uart_enable(uart_enable),
      .uart_mode  (uart_mode),
      .uart_rate  (uart_rate),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .txd        (txd),
      .uart_busy  (uart_busy),
      .uart_error (uart_error),
      .update_ok  (update_ok)
   );

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Line model: the whole frame is expanded into one line level per clock cycle.
   function automatic void push_frame(input logic [7:0] d, input logic [2:0] m, input int r);
      bit bits[$];
      bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) bits.push_back(d[k]);
      if (m[0]) bits.push_back((^d) ^ m[1]);
      bits.push_back(1'b1);
      if (m[2]) bits.push_back(1'b1);
      foreach (bits[k])
         for (int c = 0; c < r; c++) mq.push_back(bits[k]);
   endfunction

   always @(posedge clk) begin
      bit acc;
      acc = !rst && (mq.size() == 0) && uart_enable && (uart_rate >= 16'd4) && tx_valid;
      if (rst) begin
         mq.delete();
         m_err = 1'b0;
      end else begin
         if (mq.size() > 0) void'(mq.pop_front());
         if (acc) push_frame(tx_data, uart_mode, int'(uart_rate));
         if (tx_valid && uart_enable && uart_rate < 16'd4) m_err = 1'b1;
         else if (!uart_enable) m_err = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("txd", txd, (mq.size() != 0) ? mq[0] : 1'b1);
         check("uart_busy", uart_busy, mq.size() != 0);
         check("update_ok", update_ok, mq.size() == 0);
         check("tx_ready", tx_ready,
               !rst && (mq.size() == 0) && uart_enable && (uart_rate >= 16'd4));
         check("uart_error", uart_error, m_err);
      end
   end

   task automatic send(input logic [7:0] d, input logic [2:0] m, input logic [15:0] r);
      #1;
      tx_data   = d;
      uart_mode = m;
      uart_rate = r;
      tx_valid  = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
   endtask

   // Records txd each cycle while busy; returns at the first idle negedge.
   task automatic capture(input int maxc, output int n);
      n = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (!uart_busy) break;
         cap[n] = txd;
         n++;
      end
   endtask

   initial begin
      int n1;
      int n2;
      int zeros;
      rst = 1'b1; uart_enable = 1'b1; uart_mode = 3'd0; uart_rate = 16'd4;
      tx_valid = 1'b0; tx_data = 8'd0;
      @(posedge clk);
      #1 chk_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_tx_ready", tx_ready, 1'b0);
      check("rst_txd", txd, 1'b1);
      check("rst_busy", uart_busy, 1'b0);
      check("rst_update_ok", update_ok, 1'b1);
      check("rst_error", uart_error, 1'b0);
      #1 rst = 1'b0;

      // 0x55, 8N1, rate 4: alternating line, 40 busy cycles
      send(8'h55, 3'b000, 16'd4);
      capture(100, n1);
      check_int("f55_len", n1, 40);
      check("f55_start", cap[1], 1'b0);
      check("f55_bit0", cap[5], 1'b1);
      check("f55_bit1", cap[9], 1'b0);
      check("f55_bit7", cap[33], 1'b0);
      check("f55_stop", cap[37], 1'b1);

      // 0x07 with even then odd parity
      send(8'h07, 3'b001, 16'd4);
      capture(100, n1);
      check_int("par_even_len", n1, 44);
      check("par_even_bit", cap[37], 1'b1);
      send(8'h07, 3'b011, 16'd4);
      capture(100, n1);
      check_int("par_odd_len", n1, 44);
      check("par_odd_bit", cap[37], 1'b0);

      // Back-to-back with two stop bits, valid held
      #1;
      tx_data = 8'hA5; uart_mode = 3'b100; uart_rate = 16'd4; tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_data = 8'h3C;
      capture(100, n1);
      check_int("b2b_len1", n1, 44);
      check("b2b_bit0", cap[5], 1'b1);
      check("b2b_bit1", cap[9], 1'b0);
      check("b2b_stop_first", cap[36], 1'b1);
      check("b2b_stop_last", cap[43], 1'b1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      capture(100, n2);
      check_int("b2b_len2", n2, 44);
      check("b2b2_bit0", cap[5], 1'b0);
      check("b2b2_bit2", cap[13], 1'b1);
      check_int("b2b_total", n1 + 1 + n2, 89);

      // Illegal divisor
      #1;
      uart_rate = 16'd2; uart_mode = 3'b000; tx_valid = 1'b1;
      @(negedge clk);
      check("bad_rate_ready", tx_ready, 1'b0);
      @(posedge clk);
      #1;
      check("bad_rate_error", uart_error, 1'b1);
      check("bad_rate_txd", txd, 1'b1);
      uart_enable = 1'b0; tx_valid = 1'b0;
      @(posedge clk);
      #1;
      check("error_cleared", uart_error, 1'b0);
      uart_enable = 1'b1;

      // Mid-frame rate change and enable drop
      send(8'h96, 3'b000, 16'd4);
      n1 = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!uart_busy) break;
         cap[n1] = txd;
         n1++;
         @(posedge clk);
         #1;
         if (c == 9) uart_rate = 16'd8;
         if (c == 19) uart_enable = 1'b0;
      end
      check_int("midchg_len", n1, 40);
      check("midchg_bit0", cap[5], 1'b0);
      check("midchg_bit1", cap[9], 1'b1);
      check("midchg_bit7", cap[33], 1'b1);
      #1 tx_valid = 1'b1;
      @(negedge clk);
      check("disabled_ready", tx_ready, 1'b0);
      #1;
      tx_valid = 1'b0; uart_enable = 1'b1; uart_rate = 16'd4;

      // Reset mid-frame
      send(8'h00, 3'b000, 16'd4);
      repeat (14) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_txd", txd, 1'b1);
      check("abort_busy", uart_busy, 1'b0);
      check("abort_update_ok", update_ok, 1'b1);
      zeros = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) zeros++;
      end
      check_int("abort_no_bits", zeros, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
